// File: rtl/asmi_readback.sv
// asmi_readback: reads num_blocks 256-byte flash pages through ASMI and streams them, bit-reversed, into the Tx FIFO.
// Define ASMI_READBACK_CHECKSUM_EN to build the 16-bit running byte checksum; otherwise read_checksum is tied to 0.
module asmi_readback #(
    parameter logic [23:0] START_ADDR = 24'h100000,
    parameter int unsigned MAX_BLOCKS = 4096,
    parameter int unsigned FIFO_SPACE = 1792
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        read_req,
    output logic        read_ACK,
    input  logic [13:0] num_blocks,
    output logic        active,
    output logic [23:0] asmi_addr,
    output logic        asmi_rden,
    output logic        asmi_read,
    input  logic [7:0]  asmi_dataout,
    input  logic        asmi_data_valid,
    input  logic        asmi_busy,
    input  logic [10:0] tx_used,
    output logic        tx_wrreq,
    output logic [7:0]  tx_data,
    output logic        block_ready,
    input  logic        block_ready_ACK,
    output logic        read_done,
    input  logic        read_done_ACK,
    output logic [15:0] read_checksum
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ACCEPT,
        S_WAIT_SPACE,
        S_START,
        S_STREAM,
        S_STOP,
        S_GUARD1,
        S_GUARD2,
        S_NOTIFY,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        read_ack_q, read_ack_d;
    logic        active_q, active_d;
    logic [23:0] addr_q, addr_d;
    logic        rden_q, rden_d;
    logic        read_q, read_d;
    logic        wrreq_q, wrreq_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        block_ready_q, block_ready_d;
    logic        read_done_q, read_done_d;
    logic [12:0] count_q, count_d;
    logic [12:0] page_q, page_d;
    logic [8:0]  byte_cnt_q, byte_cnt_d;

    // Flash stores bytes LSB-first; the PC expects them back MSB-first.
    function automatic logic [7:0] bit_rev(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

    always_comb begin
        state_d       = state_q;
        read_ack_d    = 1'b0;
        active_d      = active_q;
        addr_d        = addr_q;
        rden_d        = rden_q;
        read_d        = 1'b0;
        wrreq_d       = 1'b0;
        tx_data_d     = 8'h00;
        block_ready_d = block_ready_q;
        read_done_d   = read_done_q;
        count_d       = count_q;
        page_d        = page_q;
        byte_cnt_d    = byte_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (read_req) begin
                    state_d    = S_ACCEPT;
                    read_ack_d = 1'b1;
                    active_d   = 1'b1;
                    addr_d     = START_ADDR;
                    page_d     = 13'd0;
                    count_d    = (num_blocks > 14'(MAX_BLOCKS)) ? 13'(MAX_BLOCKS) : num_blocks[12:0];
                end
            end
            S_ACCEPT: begin
                if (count_q == 13'd0) begin
                    state_d     = S_DONE;
                    read_done_d = 1'b1;
                end else begin
                    state_d = S_WAIT_SPACE;
                end
            end
            S_WAIT_SPACE: begin
                if (!asmi_busy && (32'(tx_used) < FIFO_SPACE)) begin
                    state_d = S_START;
                    rden_d  = 1'b1;
                    read_d  = 1'b1;
                end
            end
            S_START: begin
                byte_cnt_d = 9'd0;
                state_d    = S_STREAM;
            end
            S_STREAM: begin
                // A valid arriving in the same cycle the count hits 256 is dropped.
                if (byte_cnt_q == 9'd256) begin
                    state_d = S_STOP;
                    rden_d  = 1'b0;
                end else if (asmi_data_valid) begin
                    wrreq_d    = 1'b1;
                    tx_data_d  = bit_rev(asmi_dataout);
                    byte_cnt_d = byte_cnt_q + 9'd1;
                end
            end
            S_STOP: begin
                addr_d  = addr_q + 24'd256;
                page_d  = page_q + 13'd1;
                state_d = S_GUARD1;
            end
            S_GUARD1: begin
                if (!asmi_busy) begin
                    state_d = S_GUARD2;
                end
            end
            S_GUARD2: begin
                state_d       = S_NOTIFY;
                block_ready_d = 1'b1;
            end
            S_NOTIFY: begin
                if (block_ready_ACK) begin
                    block_ready_d = 1'b0;
                    if (page_q == count_q) begin
                        state_d     = S_DONE;
                        read_done_d = 1'b1;
                    end else begin
                        state_d = S_WAIT_SPACE;
                    end
                end
            end
            S_DONE: begin
                if (read_done_ACK) begin
                    read_done_d = 1'b0;
                    active_d    = 1'b0;
                    addr_d      = START_ADDR;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            read_ack_q    <= 1'b0;
            active_q      <= 1'b0;
            addr_q        <= START_ADDR;
            rden_q        <= 1'b0;
            read_q        <= 1'b0;
            wrreq_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            block_ready_q <= 1'b0;
            read_done_q   <= 1'b0;
            count_q       <= 13'd0;
            page_q        <= 13'd0;
            byte_cnt_q    <= 9'd0;
        end else begin
            state_q       <= state_d;
            read_ack_q    <= read_ack_d;
            active_q      <= active_d;
            addr_q        <= addr_d;
            rden_q        <= rden_d;
            read_q        <= read_d;
            wrreq_q       <= wrreq_d;
            tx_data_q     <= tx_data_d;
            block_ready_q <= block_ready_d;
            read_done_q   <= read_done_d;
            count_q       <= count_d;
            page_q        <= page_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

`ifdef ASMI_READBACK_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Cleared on the way into ACCEPT, then summed over exactly the bytes written to the FIFO.
    always_comb begin
        csum_d = csum_q;
        if (state_d == S_ACCEPT) begin
            csum_d = 16'h0000;
        end else if (wrreq_d) begin
            csum_d = csum_q + {8'h00, tx_data_d};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            csum_q <= 16'h0000;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign read_checksum = csum_q;
`else
    assign read_checksum = 16'h0000;
`endif

    assign read_ACK    = read_ack_q;
    assign active      = active_q;
    assign asmi_addr   = addr_q;
    assign asmi_rden   = rden_q;
    assign asmi_read   = read_q;
    assign tx_wrreq    = wrreq_q;
    assign tx_data     = tx_data_q;
    assign block_ready = block_ready_q;
    assign read_done   = read_done_q;

endmodule

// File: tb/tb_asmi_readback.sv
// Bench for asmi_readback: ASMI flash model, Tx framer responder, and a scoreboard of expected FIFO bytes and read addresses.
module tb_asmi_readback;

    localparam logic [23:0] START = 24'h100000;
    localparam int TB_MAX = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_req;
    logic        read_ACK;
    logic [13:0] num_blocks;
    logic        active;
    logic [23:0] asmi_addr;
    logic        asmi_rden;
    logic        asmi_read;
    logic [7:0]  asmi_dataout;
    logic        asmi_data_valid;
    logic        asmi_busy;
    logic [10:0] tx_used;
    logic        tx_wrreq;
    logic [7:0]  tx_data;
    logic        block_ready;
    logic        block_ready_ACK;
    logic        read_done;
    logic        read_done_ACK;
    logic [15:0] read_checksum;

    asmi_readback #(
        .START_ADDR(START),
        .MAX_BLOCKS(TB_MAX),
        .FIFO_SPACE(1792)
    ) dut (
        .clock(clk),
        .reset(reset),
        .read_req(read_req),
        .read_ACK(read_ACK),
        .num_blocks(num_blocks),
        .active(active),
        .asmi_addr(asmi_addr),
        .asmi_rden(asmi_rden),
        .asmi_read(asmi_read),
        .asmi_dataout(asmi_dataout),
        .asmi_data_valid(asmi_data_valid),
        .asmi_busy(asmi_busy),
        .tx_used(tx_used),
        .tx_wrreq(tx_wrreq),
        .tx_data(tx_data),
        .block_ready(block_ready),
        .block_ready_ACK(block_ready_ACK),
        .read_done(read_done),
        .read_done_ACK(read_done_ACK),
        .read_checksum(read_checksum)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_q[$];
    logic [23:0] exp_addr_q[$];
    logic [15:0] exp_sum;
    int          exp_pages;
    int          flash_mode = 0;
    bit          tx_used_hold = 1'b0;
    bit          preack = 1'b0;

    int wr_count = 0;
    int reads_total = 0;
    int rden_cycles = 0;
    int br_cycles = 0;
    int blocks_seen = 0;
    int ack_cycles = 0;
    bit br_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Raw flash content (LSB-first as stored) for a given byte address.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (flash_mode == 0) return a[7:0];
        if (flash_mode == 1) return 8'hFF;
        return 8'(a[7:0] * 8'd37) ^ a[15:8] ^ 8'h5A;
    endfunction

    // ASMI model: after a read strobe, deliver bytes with random gaps plus one surplus byte; stray valids while rden is low.
    initial begin
        logic [23:0] base;
        int idx;
        asmi_dataout = 8'h00;
        asmi_data_valid = 1'b0;
        asmi_busy = 1'b0;
        forever begin
            @(posedge clk); #1;
            asmi_data_valid = 1'b0;
            if (asmi_read && asmi_rden) begin
                base = asmi_addr;
                asmi_busy = 1'b1;
                idx = 0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                while (asmi_rden && idx < 257) begin
                    if ($urandom_range(0, 3) == 0) begin
                        asmi_data_valid = 1'b0;
                    end else begin
                        asmi_data_valid = 1'b1;
                        asmi_dataout = flash_byte(base + 24'(idx));
                        idx++;
                    end
                    @(posedge clk); #1;
                end
                asmi_data_valid = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                asmi_busy = 1'b0;
            end else if (!asmi_rden && $urandom_range(0, 7) == 0) begin
                asmi_data_valid = 1'b1;
                asmi_dataout = 8'($urandom);
            end
        end
    end

    initial begin
        tx_used = 11'd0;
        forever begin
            @(negedge clk);
            tx_used = tx_used_hold ? 11'd1800 : 11'($urandom_range(0, 1791));
        end
    end

    // Tx framer: acknowledge block_ready after a short random delay, drop the ACK once it clears.
    initial begin
        block_ready_ACK = 1'b0;
        forever begin
            @(negedge clk);
            if (!preack) begin
                if (block_ready && !block_ready_ACK) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    block_ready_ACK = 1'b1;
                end else if (!block_ready) begin
                    block_ready_ACK = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT writes the FIFO or strobes a flash read.
    initial begin
        logic [7:0] e;
        logic [23:0] ea;
        forever begin
            @(negedge clk);
            if (tx_wrreq) begin
                wr_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr: got data 0x%0h, expected no write", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e));
                end
            end
            if (asmi_read) begin
                reads_total++;
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_read: got addr 0x%0h, expected no read", asmi_addr);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check("read_addr", 32'(asmi_addr), 32'(ea));
                end
            end
            if (asmi_rden) rden_cycles++;
            if (read_ACK) ack_cycles++;
            if (block_ready) begin
                br_cycles++;
                if (!br_prev) blocks_seen++;
            end
            br_prev = block_ready;
        end
    end

    task automatic request(input logic [13:0] n, input int mode);
        logic [7:0] e;
        exp_pages = (int'(n) > TB_MAX) ? TB_MAX : int'(n);
        flash_mode = mode;
        exp_sum = 16'h0000;
        for (int p = 0; p < exp_pages; p++) begin
            exp_addr_q.push_back(START + 24'(p * 256));
            for (int b = 0; b < 256; b++) begin
                e = rev8(flash_byte(START + 24'(p * 256 + b)));
                exp_q.push_back(e);
                exp_sum = exp_sum + {8'h00, e};
            end
        end
        wr_count = 0;
        rden_cycles = 0;
        br_cycles = 0;
        blocks_seen = 0;
        ack_cycles = 0;
        @(negedge clk);
        num_blocks = n;
        read_req = 1'b1;
        for (int i = 0; i < 10 && !read_ACK; i++) @(negedge clk);
        check("read_ack", 32'(read_ACK), 32'd1);
        check("active_on_accept", 32'(active), 32'd1);
        read_req = 1'b0;
    endtask

    task automatic finish_session();
        logic [15:0] exp_csum;
        for (int i = 0; i < exp_pages * 700 + 100 && !read_done; i++) @(negedge clk);
        check("read_done", 32'(read_done), 32'd1);
        check("final_addr", 32'(asmi_addr), 32'(START + 24'(exp_pages * 256)));
`ifdef ASMI_READBACK_CHECKSUM_EN
        exp_csum = exp_sum;
`else
        exp_csum = 16'h0000;
`endif
        check("checksum", 32'(read_checksum), 32'(exp_csum));
        check("blocks_seen", 32'(blocks_seen), 32'(exp_pages));
        check("bytes_missing", 32'(exp_q.size()), 32'd0);
        check("reads_missing", 32'(exp_addr_q.size()), 32'd0);
        check("read_ack_cycles", 32'(ack_cycles), 32'd1);
        check("active_in_done", 32'(active), 32'd1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        check("read_done_held", 32'(read_done), 32'd1);
        read_done_ACK = 1'b1;
        @(negedge clk);
        read_done_ACK = 1'b0;
        check("done_cleared", 32'(read_done), 32'd0);
        check("active_cleared", 32'(active), 32'd0);
        check("idle_addr", 32'(asmi_addr), 32'(START));
        exp_q.delete();
        exp_addr_q.delete();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #900000;
        checks++;
        failures++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        reset = 1'b1;
        read_req = 1'b0;
        num_blocks = 14'd0;
        read_done_ACK = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_addr", 32'(asmi_addr), 32'(START));
        check("rst_rden", 32'(asmi_rden), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_outputs", 32'({read_ACK, asmi_read, tx_wrreq, block_ready, read_done}), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_checksum", 32'(read_checksum), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single page of 0x00..0xFF: bit-reversed bytes, one read at START.
        request(14'd1, 0);
        finish_session();

        // FIFO nearly full: no flash read may start until tx_used drops.
        tx_used_hold = 1'b1;
        request(14'd3, 2);
        begin
            int r0;
            r0 = reads_total;
            repeat (50) @(negedge clk);
            check("no_read_while_full", 32'(reads_total - r0), 32'd0);
        end
        tx_used_hold = 1'b0;
        finish_session();

        // Zero pages: straight to DONE without touching the flash.
        request(14'd0, 0);
        finish_session();
        check("zero_rden_cycles", 32'(rden_cycles), 32'd0);

        // Oversized request is clamped to the page limit.
        request(14'h3FFF, 2);
        finish_session();

        // ACK already high when block_ready rises: single-cycle pulse.
        preack = 1'b1;
        block_ready_ACK = 1'b1;
        request(14'd1, 2);
        finish_session();
        check("preack_br_cycles", 32'(br_cycles), 32'd1);
        preack = 1'b0;
        block_ready_ACK = 1'b0;

        // All-0xFF page for the checksum.
        request(14'd1, 1);
        finish_session();

        for (int s = 0; s < 3; s++) begin
            request(14'($urandom_range(1, 3)), 2);
            finish_session();
        end

        // Reset in the middle of page 2, then a clean restart.
        request(14'd3, 2);
        for (int i = 0; i < 3000 && wr_count < 612; i++) @(negedge clk);
        check("reset_point_reached", 32'(wr_count >= 612), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_rden", 32'(asmi_rden), 32'd0);
        check("midrst_outputs", 32'({read_ACK, active, asmi_read, tx_wrreq, block_ready, read_done}), 32'd0);
        check("midrst_addr", 32'(asmi_addr), 32'(START));
        check("midrst_checksum", 32'(read_checksum), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (6) @(negedge clk);
        request(14'd1, 0);
        finish_session();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/asmi_readback.md
# asmi_readback

Flash readback engine for the EPCS16 configuration device. On a PC request it reads `num_blocks` 256-byte pages from the upper 1 MB of flash through the ASMI megafunction and streams the bytes into the Tx FIFO. It handshakes each page with the Tx framer so the PC can verify a freshly programmed image. It shares the ASMI port with the flash programmer; the top-level mux grants the port to this block only while `active` is high.

## Interface
Parameters:
- `START_ADDR`, 24'h100000, first flash byte read.
- `MAX_BLOCKS`, 4096, page count clamp (1 MB / 256).
- `FIFO_SPACE`, 1792, page read starts only when `tx_used` < this value.

Ports:
- `clock`  in  1  single system clock; all logic on posedge; also drives ASMI `clkin`.
- `reset`  in  1  synchronous, active-high.
- `read_req`  in  1  level from Rx decoder: start readback.
- `read_ACK`  out  1  pulses high for 1 cycle when `read_req` is accepted.
- `num_blocks`  in  14  pages to read; sampled on accept.
- `active`  out  1  high from accept until return to IDLE.
- `asmi_addr`  out  24  ASMI `addr`.
- `asmi_rden`  out  1  ASMI `rden`.
- `asmi_read`  out  1  ASMI `read` strobe.
- `asmi_dataout`  in  8  ASMI `dataout`, LSB-first bit order.
- `asmi_data_valid`  in  1  ASMI byte strobe.
- `asmi_busy`  in  1  ASMI `busy`.
- `tx_used`  in  11  Tx FIFO fill level.
- `tx_wrreq`  out  1  Tx FIFO write.
- `tx_data`  out  8  byte to Tx FIFO, MSB-first.
- `block_ready`  out  1  page in FIFO; held until `block_ready_ACK`.
- `block_ready_ACK`  in  1  from Tx framer.
- `read_done`  out  1  all pages sent; held until `read_done_ACK`.
- `read_done_ACK`  in  1  from Tx framer.
- `read_checksum`  out  16  running byte sum (see Configuration).

## Operation
- `tx_data` = bit-reverse of `asmi_dataout`, so the PC gets back the bytes it sent for programming.
- Block count = min(`num_blocks`, `MAX_BLOCKS`). A count of 0 goes straight to DONE with no flash access.
- States:
  - IDLE: all outputs at reset value; `read_req` -> ACCEPT.
  - ACCEPT: `read_ACK`=1 (one cycle only); `asmi_addr`=`START_ADDR`; page=0; checksum=0; -> WAIT_SPACE, or -> DONE if the count is 0.
  - WAIT_SPACE: wait for !`asmi_busy` && `tx_used` < `FIFO_SPACE` -> START.
  - START: `asmi_rden`=1, `asmi_read`=1 for exactly one cycle; byte_count=0 -> STREAM.
  - STREAM: `asmi_rden` held high; each `asmi_data_valid` writes one byte and increments byte_count (9 bits). At byte_count==256 -> STOP.
  - STOP: `asmi_rden`=0; `asmi_addr` += 256; page += 1 -> GUARD1 -> GUARD2. GUARD1/2 are a two-cycle delay after `asmi_busy` is seen low, per the Altera recommendation; while busy, stay in GUARD1.
  - GUARD2 -> NOTIFY.
  - NOTIFY: `block_ready`=1 until `block_ready_ACK`, then clear. Exit -> DONE if page==count, else -> WAIT_SPACE.
  - DONE: `read_done`=1 until `read_done_ACK` -> IDLE.
- `read_req` is ignored outside IDLE.

## Timing
- Reset values: every output 0, except `asmi_addr`=`START_ADDR`.
- `tx_wrreq`/`tx_data` are registered: they appear 1 cycle after `asmi_data_valid`. Back-to-back valids give back-to-back writes.
- Any `asmi_data_valid` outside STREAM, or after the 256th byte, is discarded: no FIFO write, no count change.
- `asmi_addr` is stable from START until STOP. The final address after N pages is `START_ADDR` + 256·N, and never exceeds 24'h200000.
- `block_ready_ACK` already high on entry to NOTIFY: `block_ready` is asserted for one cycle only.
- `reset` mid-operation: next cycle all outputs return to reset values (including `asmi_rden`=0) and the state is IDLE. There are no partial-page handshakes.
- ACK inputs are not edge-detected. The Tx framer must drop an ACK before the next handshake it answers.

## Configuration
- `ASMI_READBACK_CHECKSUM_EN` defined:
  - `read_checksum` is the mod-2^16 sum of all MSB-first bytes written this session.
  - Cleared in ACCEPT; stable and valid while `read_done`=1.
- Not defined: `read_checksum` is tied to 16'h0000 and no adder is built.

## Test plan
- `num_blocks`=1, flash page = 0x00..0xFF LSB-first → 256 `tx_wrreq` carrying bit-reversed values (byte 0x01 → 0x80), one `block_ready` then one `read_done`, and `asmi_read` pulses exactly once at address 0x100000.
- `num_blocks`=3 with `tx_used`=1800 held for 50 cycles before dropping to 0 → no `asmi_read` while `tx_used` ≥ 1792, then reads at 0x100000, 0x100100 and 0x100200.
- `num_blocks`=0 → `read_ACK`, then `read_done`; `asmi_rden` stays 0 throughout.
- `num_blocks`=14'h3FFF → reading stops after 4096 pages; last `asmi_addr` = 0x1FFF00.
- `reset` asserted at byte 100 of page 2 → one cycle later `asmi_rden`=0 and all outputs are 0; a new `read_req` restarts at 0x100000.
- With the macro defined, 256 bytes of 0xFF (reversed value still 0xFF) → `read_checksum`=16'hFF00 at `read_done`; without the macro → 16'h0000.
